wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 16-bit pipelined CPU; this is the write side of the register file, whose read side produces op1/op2/Reg15.
- Registers results from the execute/memory side and selects ALU result or memory data (MemToReg).
- Drives Writedata/Writereg/RegWrite into the register file.
- Sequences the two-register write (rd, then R15) required by R15-class instructions (multiply/divide high half), stalling upstream for one cycle.

Parameters:
- DATA_W, 16, datapath / register width
- REG_AW, 4, register index width (16 registers)
- HI_REG, 15, index of the implicit high-half register

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- in_valid  input  1  upstream result valid this cycle
- in_ready  output  1  stage can accept a result this cycle
- alu_result  input  DATA_W  ALU result (low half for R15 ops)
- alu_result_hi  input  DATA_W  high half for R15 ops
- mem_rdata  input  DATA_W  data memory read data
- dest_reg  input  REG_AW  destination register rd
- MemToReg  input  1  1 = write mem_rdata, 0 = write alu_result
- RegWrite_in  input  1  instruction writes rd
- R15_in  input  1  instruction also writes alu_result_hi to HI_REG
- Writedata  output  DATA_W  register file write data
- Writereg  output  REG_AW  register file write index
- RegWrite  output  1  register file write enable, one-cycle pulse per write
- busy  output  1  second write of an R15 sequence pending

Behaviour:
- Transfer: handshake completes on in_valid && in_ready at a rising edge. No partial acceptance.
- Reset (reset==0 at edge):
  - state=IDLE, RegWrite=0, Writedata=0, Writereg=0, busy=0, in_ready=1.
  - Any pending R15 write is discarded.
- States: IDLE, WR_RD, WR_HI.
- IDLE: on transfer, latch the selected data (MemToReg ? mem_rdata : alu_result), dest_reg, alu_result_hi and flags, then branch:
  - RegWrite_in=1, R15_in=0 -> WR_RD; r15_pend=0.
  - RegWrite_in=1, R15_in=1 -> WR_RD; r15_pend=1.
  - RegWrite_in=0, R15_in=1 -> WR_HI (single write of the high half).
  - RegWrite_in=0, R15_in=0 -> accepted as a bubble; stay IDLE; no write.
- WR_RD:
  - RegWrite=1, Writereg=latched rd, Writedata=latched data.
  - Next state is WR_HI if r15_pend, else IDLE; a new transfer in this cycle is allowed.
- WR_HI:
  - RegWrite=1, Writereg=HI_REG, Writedata=latched hi.
  - Next state is IDLE, or the target state of a transfer accepted this cycle.
- in_ready = 0 only in WR_RD with r15_pend=1; 1 otherwise. This gives a one-cycle stall per R15 op with both writes.
- busy = (state==WR_RD && r15_pend).
- Latency: a transfer accepted at edge N produces the rd write visible in cycle N+1. The HI write (if any) follows in N+2.
- Back-to-back: continuous writes at full rate for non-R15 ops.
- dest_reg==HI_REG with R15 op: the rd write occurs first, then the HI write overwrites; the final value is the high half.
- Outputs are registered; Writedata/Writereg hold their last values when RegWrite=0.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_reg (REG_AW), fwd_data (DATA_W), which mirror the write currently being performed (the same cycle as the RegWrite pulse) for the execute-stage bypass mux. fwd_valid=0 in reset and in IDLE.
- Undefined: these ports do not exist and there is no bypass logic.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and REG_AW constants;
  - the HI_REG index;
  - the wb_state_t encoding (IDLE=2'd0, WR_RD=2'd1, WR_HI=2'd2).
- One sub-module is natural: wb_mux, a combinational MemToReg select. Everything else stays in wb_stage.

Test Plan:
- Reset: hold reset=0 three cycles with in_valid=1 -> RegWrite=0, Writedata=0000, Writereg=0, in_ready=1.
- ALU write: alu_result=1234, dest_reg=3, RegWrite_in=1, MemToReg=0 at edge N -> cycle N+1 shows RegWrite=1, Writereg=3, Writedata=1234; RegWrite=0 at N+2.
- Load: mem_rdata=BEEF, alu_result=0000, MemToReg=1, dest_reg=7 -> Writereg=7, Writedata=BEEF. Then issue 4 back-to-back non-R15 ops -> 4 consecutive RegWrite pulses with no stall.
- R15 op: alu_result=00C8, alu_result_hi=0001, dest_reg=2, R15_in=1, with a second op queued -> N+1: (2,00C8) with in_ready=0 and busy=1; N+2: (15,0001); the queued op writes at N+3.
- Reset mid-sequence: assert reset=0 during WR_RD of an R15 op -> no HI write occurs; state=IDLE and in_ready=1 after release.
- Bubble and edge cases:
  - RegWrite_in=0, R15_in=0 -> no pulse.
  - dest_reg=15 with R15 op, lo=AAAA, hi=5555 -> writes AAAA then 5555 to reg 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, implicit high-half register index and writeback state encoding
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam logic [REG_AW-1:0] HI_REG = 4'd15;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_RD = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: MemToReg select between ALU result and load data
module wb_mux
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         sel,
  input  logic [W-1:0] alu,
  input  logic [W-1:0] mem,
  output logic [W-1:0] y
);
  assign y = sel ? mem : alu;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: register-file writeback with rd-then-R15 sequencing; WB_FWD_EN adds a bypass mirror of the current write
module wb_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_result_hi,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              MemToReg,
  input  logic              RegWrite_in,
  input  logic              R15_in,
  output logic [DATA_W-1:0] Writedata,
  output logic [REG_AW-1:0] Writereg,
  output logic              RegWrite,
  output logic              busy
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);
  wb_state_t state, state_n;
  logic r15_pend, pend_n;
  logic [DATA_W-1:0] hi_q, hi_n, sel_data, wd_n;
  logic [REG_AW-1:0] wr_n;
  logic xfer, hold_hi;
  wb_mux #(.W(DATA_W)) u_mux (.sel(MemToReg), .alu(alu_result), .mem(mem_rdata), .y(sel_data));
  assign busy = (state == WR_RD) && r15_pend;
  assign in_ready = !busy;
  assign xfer = in_valid && in_ready;
  assign hold_hi = busy;
`ifdef WB_FWD_EN
  assign fwd_valid = RegWrite;
  assign fwd_reg = Writereg;
  assign fwd_data = Writedata;
`endif
  // next state and the write to present in the following cycle; pending HI write takes priority
  always_comb begin
    state_n = IDLE;
    pend_n = 1'b0;
    hi_n = hi_q;
    wd_n = Writedata;
    wr_n = Writereg;
    if (hold_hi) begin
      state_n = WR_HI;
      wd_n = hi_q;
      wr_n = HI_REG;
    end else if (xfer) begin
      hi_n = alu_result_hi;
      pend_n = RegWrite_in && R15_in;
      state_n = RegWrite_in ? WR_RD : R15_in ? WR_HI : IDLE;
      wd_n = RegWrite_in ? sel_data : R15_in ? alu_result_hi : Writedata;
      wr_n = RegWrite_in ? dest_reg : R15_in ? HI_REG : Writereg;
    end
  end
  // state and registered register-file write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      r15_pend <= 1'b0;
      hi_q <= '0;
      RegWrite <= 1'b0;
      Writedata <= '0;
      Writereg <= '0;
    end else begin
      state <= state_n;
      r15_pend <= pend_n;
      hi_q <= hi_n;
      RegWrite <= state_n != IDLE;
      Writedata <= wd_n;
      Writereg <= wr_n;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage
module tb_wb_stage;
  import cpu_pkg::*;
  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0, in_ready;
  logic [DATA_W-1:0] alu_result = '0, alu_result_hi = '0, mem_rdata = '0, Writedata;
  logic [REG_AW-1:0] dest_reg = '0, Writereg;
  logic MemToReg = 0, RegWrite_in = 0, R15_in = 0, RegWrite, busy;
  int checks = 0, errors = 0;
`ifdef WB_FWD_EN
  logic fwd_valid;
  logic [REG_AW-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;
`endif
  wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_result_hi(alu_result_hi), .mem_rdata(mem_rdata),
    .dest_reg(dest_reg), .MemToReg(MemToReg), .RegWrite_in(RegWrite_in), .R15_in(R15_in),
    .Writedata(Writedata), .Writereg(Writereg), .RegWrite(RegWrite), .busy(busy)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
  );
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic r15, input logic m2r,
                       input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] lo,
                       input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] md);
    in_valid = v; RegWrite_in = rw; R15_in = r15; MemToReg = m2r;
    dest_reg = rd; alu_result = lo; alu_result_hi = hi; mem_rdata = md;
  endtask

  task automatic test_reset;
    reset = 0;
    drive(1, 1, 1, 0, 4'd5, 16'h1111, 16'h2222, 16'h3333);
    repeat (3) step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWrite); end
    checks++; if (Writedata !== 16'h0000) begin errors++; $display("FAIL reset_wdata got %h exp 0000", Writedata); end
    checks++; if (Writereg !== 4'd0) begin errors++; $display("FAIL reset_wreg got %0d exp 0", Writereg); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready got rdy=%b busy=%b exp 1/0", in_ready, busy); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_release got %b exp 0", RegWrite); end
  endtask

  task automatic test_alu_write;
    drive(1, 1, 0, 0, 4'd3, 16'h1234, 16'h0, 16'hFFFF);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({RegWrite, Writereg, Writedata} !== {1'b1, 4'd3, 16'h1234}) begin errors++; $display("FAIL alu_write got %b/%0d/%h exp 1/3/1234", RegWrite, Writereg, Writedata); end
    step();
    checks++; if ({RegWrite, Writereg, Writedata} !== {1'b0, 4'd3, 16'h1234}) begin errors++; $display("FAIL alu_hold got %b/%0d/%h exp 0/3/1234", RegWrite, Writereg, Writedata); end
  endtask

  task automatic test_back_to_back;
    drive(1, 1, 0, 1, 4'd7, 16'h0000, 16'h0, 16'hBEEF);
    step();
    checks++; if ({RegWrite, Writereg, Writedata} !== {1'b1, 4'd7, 16'hBEEF}) begin errors++; $display("FAIL load got %b/%0d/%h exp 1/7/beef", RegWrite, Writereg, Writedata); end
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 0, 0, 4'(i), 16'(i * 16'h1111), 16'h0, 16'h0);
      step();
      checks++; if ({RegWrite, in_ready, Writereg, Writedata} !== {1'b1, 1'b1, 4'(i), 16'(i * 16'h1111)}) begin errors++; $display("FAIL b2b_%0d got %b/%b/%0d/%h exp 1/1/%0d/%h", i, RegWrite, in_ready, Writereg, Writedata, i, 16'(i * 16'h1111)); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", RegWrite); end
  endtask

  task automatic test_r15;
    drive(1, 1, 1, 0, 4'd2, 16'h00C8, 16'h0001, 16'h0);
    step();
    drive(1, 1, 0, 0, 4'd4, 16'h4444, 16'h0, 16'h0);
    checks++; if ({RegWrite, Writereg, Writedata, in_ready, busy} !== {1'b1, 4'd2, 16'h00C8, 1'b0, 1'b1}) begin errors++; $display("FAIL r15_rd got %b/%0d/%h rdy=%b busy=%b exp 1/2/00c8 0/1", RegWrite, Writereg, Writedata, in_ready, busy); end
    step();
    checks++; if ({RegWrite, Writereg, Writedata, in_ready, busy} !== {1'b1, 4'd15, 16'h0001, 1'b1, 1'b0}) begin errors++; $display("FAIL r15_hi got %b/%0d/%h rdy=%b busy=%b exp 1/15/0001 1/0", RegWrite, Writereg, Writedata, in_ready, busy); end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({RegWrite, Writereg, Writedata} !== {1'b1, 4'd4, 16'h4444}) begin errors++; $display("FAIL r15_queued got %b/%0d/%h exp 1/4/4444", RegWrite, Writereg, Writedata); end
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL r15_end got %b exp 0", RegWrite); end
  endtask

  task automatic test_reset_mid;
    drive(1, 1, 1, 0, 4'd6, 16'h6666, 16'h7777, 16'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    reset = 0;
    step();
    checks++; if ({RegWrite, busy, Writedata} !== {1'b0, 1'b0, 16'h0000}) begin errors++; $display("FAIL mid_reset got %b/%b/%h exp 0/0/0000", RegWrite, busy, Writedata); end
    reset = 1;
    step();
    checks++; if ({RegWrite, in_ready, Writereg} !== {1'b0, 1'b1, 4'd0}) begin errors++; $display("FAIL mid_release got %b/%b/%0d exp 0/1/0", RegWrite, in_ready, Writereg); end
  endtask

  task automatic test_bubble;
    drive(1, 0, 0, 0, 4'd9, 16'h9999, 16'h8888, 16'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({RegWrite, in_ready, Writedata} !== {1'b0, 1'b1, 16'h0000}) begin errors++; $display("FAIL bubble got %b/%b/%h exp 0/1/0000", RegWrite, in_ready, Writedata); end
    drive(1, 0, 1, 0, 4'd9, 16'h1111, 16'h9999, 16'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({RegWrite, Writereg, Writedata, busy} !== {1'b1, 4'd15, 16'h9999, 1'b0}) begin errors++; $display("FAIL hi_only got %b/%0d/%h busy=%b exp 1/15/9999 0", RegWrite, Writereg, Writedata, busy); end
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL hi_only_end got %b exp 0", RegWrite); end
  endtask

  task automatic test_hi_dest;
    drive(1, 1, 1, 0, 4'd15, 16'hAAAA, 16'h5555, 16'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({RegWrite, Writereg, Writedata} !== {1'b1, 4'd15, 16'hAAAA}) begin errors++; $display("FAIL hidest_lo got %b/%0d/%h exp 1/15/aaaa", RegWrite, Writereg, Writedata); end
    step();
    checks++; if ({RegWrite, Writereg, Writedata} !== {1'b1, 4'd15, 16'h5555}) begin errors++; $display("FAIL hidest_hi got %b/%0d/%h exp 1/15/5555", RegWrite, Writereg, Writedata); end
    step();
    checks++; if ({RegWrite, Writereg, Writedata} !== {1'b0, 4'd15, 16'h5555}) begin errors++; $display("FAIL hidest_hold got %b/%0d/%h exp 0/15/5555", RegWrite, Writereg, Writedata); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_back_to_back();
    test_r15();
    test_reset_mid();
    test_bubble();
    test_hi_dest();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
